// File: rtl/rgb2grey_frame_ctrl.sv
// Frame sequencer for the FP16 RGB-to-grey converter: sizes the frame, feeds the external
// combinational converter and registers its grey result into a flagged one-stage output stream.
module rgb2grey_frame_ctrl #(
    parameter int W_BITS = 11,
    parameter int H_BITS = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [W_BITS-1:0] cfg_width,
    input  logic [H_BITS-1:0] cfg_height,
    output logic              busy,
    output logic              done,
    output logic              err_cfg,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [47:0]       s_pixel,
    output logic [47:0]       conv_rgb,
    input  logic [15:0]       conv_grey,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [15:0]       m_pixel,
    output logic              m_sol,
    output logic              m_eol,
    output logic              m_eof
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [W_BITS-1:0] width_q, width_d, col_q, col_d;
    logic [H_BITS-1:0] height_q, height_d, row_q, row_d;
    logic              done_q, done_d, err_cfg_q, err_cfg_d;
    logic              m_valid_q, m_valid_d, m_sol_q, m_sol_d;
    logic              m_eol_q, m_eol_d, m_eof_q, m_eof_d;
    logic [15:0]       m_pixel_q, m_pixel_d;
    logic              xfer, last_col, last_row;

    assign s_ready  = (state_q == RUN) && (!m_valid_q || m_ready);
    assign conv_rgb = (state_q == RUN) ? s_pixel : 48'h0;
    assign xfer     = s_valid && s_ready;
    assign last_col = (col_q == width_q - W_BITS'(1));
    assign last_row = (row_q == height_q - H_BITS'(1));

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign err_cfg = err_cfg_q;
    assign m_valid = m_valid_q;
    assign m_pixel = m_pixel_q;
    assign m_sol   = m_sol_q;
    assign m_eol   = m_eol_q;
    assign m_eof   = m_eof_q;

    always_comb begin
        state_d   = state_q;
        width_d   = width_q;
        height_d  = height_q;
        col_d     = col_q;
        row_d     = row_q;
        done_d    = 1'b0;
        err_cfg_d = 1'b0;
        m_valid_d = m_valid_q;
        m_pixel_d = m_pixel_q;
        m_sol_d   = m_sol_q;
        m_eol_d   = m_eol_q;
        m_eof_d   = m_eof_q;
        case (state_q)
            IDLE: begin
                // abort in IDLE masks a simultaneous start
                if (start && !abort) begin
                    if (cfg_width == '0 || cfg_height == '0) begin
                        err_cfg_d = 1'b1;
                    end else begin
                        width_d  = cfg_width;
                        height_d = cfg_height;
                        col_d    = '0;
                        row_d    = '0;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    m_pixel_d = conv_grey;
                    m_valid_d = 1'b1;
                    m_sol_d   = (col_q == '0);
                    m_eol_d   = last_col;
                    m_eof_d   = last_col && last_row;
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + H_BITS'(1);
                        end
                    end else begin
                        col_d = col_q + W_BITS'(1);
                    end
                end else if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                end
            end
            DRAIN: begin
                if (!m_valid_q || m_ready) begin
                    m_valid_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // abort drops any pending beat and never reports done
        if (abort && state_q != IDLE) begin
            state_d   = IDLE;
            m_valid_d = 1'b0;
            m_sol_d   = 1'b0;
            m_eol_d   = 1'b0;
            m_eof_d   = 1'b0;
            col_d     = '0;
            row_d     = '0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            width_q   <= '0;
            height_q  <= '0;
            col_q     <= '0;
            row_q     <= '0;
            done_q    <= 1'b0;
            err_cfg_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_pixel_q <= '0;
            m_sol_q   <= 1'b0;
            m_eol_q   <= 1'b0;
            m_eof_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            width_q   <= width_d;
            height_q  <= height_d;
            col_q     <= col_d;
            row_q     <= row_d;
            done_q    <= done_d;
            err_cfg_q <= err_cfg_d;
            m_valid_q <= m_valid_d;
            m_pixel_q <= m_pixel_d;
            m_sol_q   <= m_sol_d;
            m_eol_q   <= m_eol_d;
            m_eof_q   <= m_eof_d;
        end
    end

endmodule

// File: tb/tb_rgb2grey_frame_ctrl.sv
// Directed bench for rgb2grey_frame_ctrl: per-cycle vector table plus hand-written reset sequence.
module tb_rgb2grey_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [10:0] cfg_width, cfg_height;
    logic        busy, done, err_cfg;
    logic        s_valid, s_ready;
    logic [47:0] s_pixel, conv_rgb;
    logic [15:0] conv_grey;
    logic        m_valid, m_ready;
    logic [15:0] m_pixel;
    logic        m_sol, m_eol, m_eof;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Converter stub: grey is the blue channel.
    assign conv_grey = conv_rgb[15:0];

    rgb2grey_frame_ctrl #(.W_BITS(11), .H_BITS(11)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .busy(busy), .done(done), .err_cfg(err_cfg),
        .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel),
        .conv_rgb(conv_rgb), .conv_grey(conv_grey),
        .m_valid(m_valid), .m_ready(m_ready), .m_pixel(m_pixel),
        .m_sol(m_sol), .m_eol(m_eol), .m_eof(m_eof)
    );

    typedef struct packed {
        logic        start, abort;
        logic [10:0] w, h;
        logic        sv;
        logic [15:0] pix;
        logic        mr;
        logic        busy, srdy, mv;
        logic [15:0] mp;
        logic        sol, eol, eof, done, err;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic ab, input logic [10:0] w, input logic [10:0] h,
                       input logic sv, input logic [15:0] pix, input logic mr,
                       input logic e_busy, input logic e_srdy, input logic e_mv,
                       input logic [15:0] e_mp, input logic e_sol, input logic e_eol,
                       input logic e_eof, input logic e_done, input logic e_err);
        vec_t v;
        v = '{st, ab, w, h, sv, pix, mr, e_busy, e_srdy, e_mv, e_mp, e_sol, e_eol, e_eof,
              e_done, e_err};
        vq.push_back(v);
    endtask

    // Idle cycle with nothing expected.
    task automatic idle(input logic [10:0] w, input logic [10:0] h);
        add(0, 0, w, h, 0, 16'h0, 1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
    endtask

    task automatic drive(input vec_t v);
        start      = v.start;
        abort      = v.abort;
        cfg_width  = v.w;
        cfg_height = v.h;
        s_valid    = v.sv;
        s_pixel    = {16'hAAAA, 16'h5555, v.pix};
        m_ready    = v.mr;
    endtask

    initial begin
        vec_t z;
        z = '0;
        drive(z);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.busy", {47'd0, busy}, 48'd0);
        chk("rst.m_valid", {47'd0, m_valid}, 48'd0);
        chk("rst.m_pixel", {32'd0, m_pixel}, 48'd0);
        chk("rst.flags", {45'd0, m_sol, m_eol, m_eof}, 48'd0);
        chk("rst.done_err", {46'd0, done, err_cfg}, 48'd0);
        chk("rst.conv_rgb", conv_rgb, 48'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Plain 3x2 frame
        add(1, 0, 3, 2, 0, 16'h0, 1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
        add(0, 0, 3, 2, 1, 16'h1, 1, 1, 1, 0, 16'h0, 0, 0, 0, 0, 0);
        add(0, 0, 3, 2, 1, 16'h2, 1, 1, 1, 1, 16'h1, 1, 0, 0, 0, 0);
        add(0, 0, 3, 2, 1, 16'h3, 1, 1, 1, 1, 16'h2, 0, 0, 0, 0, 0);
        add(0, 0, 3, 2, 1, 16'h4, 1, 1, 1, 1, 16'h3, 0, 1, 0, 0, 0);
        add(0, 0, 3, 2, 1, 16'h5, 1, 1, 1, 1, 16'h4, 1, 0, 0, 0, 0);
        add(0, 0, 3, 2, 1, 16'h6, 1, 1, 1, 1, 16'h5, 0, 0, 0, 0, 0);
        add(0, 0, 3, 2, 0, 16'h0, 1, 1, 0, 1, 16'h6, 0, 1, 1, 0, 0);
        add(0, 0, 3, 2, 0, 16'h0, 1, 0, 0, 0, 16'h0, 0, 0, 0, 1, 0);
        idle(3, 2);

        // 3x2 frame with 4 stalled cycles on beat 2
        add(1, 0, 3, 2, 0, 16'h0, 1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
        add(0, 0, 3, 2, 1, 16'h1, 1, 1, 1, 0, 16'h0, 0, 0, 0, 0, 0);
        add(0, 0, 3, 2, 1, 16'h2, 1, 1, 1, 1, 16'h1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 0, 3, 2, 1, 16'h3, 0, 1, 0, 1, 16'h2, 0, 0, 0, 0, 0);
        add(0, 0, 3, 2, 1, 16'h3, 1, 1, 1, 1, 16'h2, 0, 0, 0, 0, 0);
        add(0, 0, 3, 2, 1, 16'h4, 1, 1, 1, 1, 16'h3, 0, 1, 0, 0, 0);
        add(0, 0, 3, 2, 1, 16'h5, 1, 1, 1, 1, 16'h4, 1, 0, 0, 0, 0);
        add(0, 0, 3, 2, 1, 16'h6, 1, 1, 1, 1, 16'h5, 0, 0, 0, 0, 0);
        add(0, 0, 3, 2, 0, 16'h0, 1, 1, 0, 1, 16'h6, 0, 1, 1, 0, 0);
        add(0, 0, 3, 2, 0, 16'h0, 1, 0, 0, 0, 16'h0, 0, 0, 0, 1, 0);
        idle(3, 2);

        // Zero-size rejection and abort-over-start in IDLE
        add(1, 0, 0, 5, 0, 16'h0, 1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 5, 0, 16'h0, 1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 1);
        idle(0, 5);
        add(1, 0, 4, 0, 0, 16'h0, 1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
        add(0, 0, 4, 0, 0, 16'h0, 1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 1);
        add(1, 1, 2, 1, 0, 16'h0, 1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
        idle(2, 1);
        idle(2, 1);

        // 1x1 frame; start with new size while busy must be ignored
        add(1, 0, 1, 1, 0, 16'h0, 1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
        add(1, 0, 5, 5, 1, 16'h3C00, 1, 1, 1, 0, 16'h0, 0, 0, 0, 0, 0);
        add(1, 0, 5, 5, 0, 16'h0, 1, 1, 0, 1, 16'h3C00, 1, 1, 1, 0, 0);
        add(0, 0, 5, 5, 0, 16'h0, 1, 0, 0, 0, 16'h0, 0, 0, 0, 1, 0);
        idle(5, 5);

        // 4x4 frame aborted after 5 transfers, then a 2x1 frame
        add(1, 0, 4, 4, 0, 16'h0, 1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
        add(0, 0, 4, 4, 1, 16'h11, 1, 1, 1, 0, 16'h0, 0, 0, 0, 0, 0);
        add(0, 0, 4, 4, 1, 16'h12, 1, 1, 1, 1, 16'h11, 1, 0, 0, 0, 0);
        add(0, 0, 4, 4, 1, 16'h13, 1, 1, 1, 1, 16'h12, 0, 0, 0, 0, 0);
        add(0, 0, 4, 4, 1, 16'h14, 1, 1, 1, 1, 16'h13, 0, 0, 0, 0, 0);
        add(0, 0, 4, 4, 1, 16'h15, 1, 1, 1, 1, 16'h14, 0, 1, 0, 0, 0);
        add(0, 1, 4, 4, 0, 16'h0, 0, 1, 0, 1, 16'h15, 1, 0, 0, 0, 0);
        add(0, 0, 4, 4, 0, 16'h0, 0, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
        idle(4, 4);
        add(1, 0, 2, 1, 0, 16'h0, 1, 0, 0, 0, 16'h0, 0, 0, 0, 0, 0);
        add(0, 0, 2, 1, 1, 16'h21, 1, 1, 1, 0, 16'h0, 0, 0, 0, 0, 0);
        add(0, 0, 2, 1, 1, 16'h22, 1, 1, 1, 1, 16'h21, 1, 0, 0, 0, 0);
        add(0, 0, 2, 1, 0, 16'h0, 1, 1, 0, 1, 16'h22, 0, 1, 1, 0, 0);
        add(0, 0, 2, 1, 0, 16'h0, 1, 0, 0, 0, 16'h0, 0, 0, 0, 1, 0);
        idle(2, 1);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i]);
            #1;
            chk($sformatf("v%0d.busy", i), {47'd0, busy}, {47'd0, vq[i].busy});
            chk($sformatf("v%0d.s_ready", i), {47'd0, s_ready}, {47'd0, vq[i].srdy});
            chk($sformatf("v%0d.m_valid", i), {47'd0, m_valid}, {47'd0, vq[i].mv});
            chk($sformatf("v%0d.done", i), {47'd0, done}, {47'd0, vq[i].done});
            chk($sformatf("v%0d.err_cfg", i), {47'd0, err_cfg}, {47'd0, vq[i].err});
            if (vq[i].mv) begin
                chk($sformatf("v%0d.m_pixel", i), {32'd0, m_pixel}, {32'd0, vq[i].mp});
                chk($sformatf("v%0d.sol_eol_eof", i), {45'd0, m_sol, m_eol, m_eof},
                    {45'd0, vq[i].sol, vq[i].eol, vq[i].eof});
            end
        end

        // 8x8 frame interrupted by reset after 10 pixels
        @(negedge clk);
        z = '0;
        z.start = 1'b1; z.w = 11'd8; z.h = 11'd8; z.mr = 1'b1;
        drive(z);
        @(negedge clk);
        start = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_pixel = {16'hAAAA, 16'h5555, 16'(16'h40 + i)};
            @(negedge clk);
        end
        #1;
        chk("mid.m_pixel", {32'd0, m_pixel}, 48'h49);
        chk("mid.busy", {47'd0, busy}, 48'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst.busy", {47'd0, busy}, 48'd0);
        chk("arst.s_ready", {47'd0, s_ready}, 48'd0);
        chk("arst.m_valid", {47'd0, m_valid}, 48'd0);
        chk("arst.m_pixel", {32'd0, m_pixel}, 48'd0);
        chk("arst.flags", {45'd0, m_sol, m_eol, m_eof}, 48'd0);
        chk("arst.conv_rgb", conv_rgb, 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("post_rst%0d.busy", i), {47'd0, busy}, 48'd0);
            chk($sformatf("post_rst%0d.done", i), {47'd0, done}, 48'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
